// File: rtl/dequant_stream.sv
// -----------------------------------------------------------------------------
// dequant_stream
// Streaming dequantizer: turns quantized bytes (signed INT8, or two packed
// signed INT4 nibbles) into signed OUT_W-bit values by an arithmetic left
// shift, saturating to the OUT_W range and counting saturated outputs.
//
// Configuration macro: DEQUANT_STREAM_INT4_EN
//   defined   -> packed INT4 unpacking, NIB_HI state and nibble store present
//   undefined -> mode is ignored, every byte is INT8, FSM stays in NIB_LO
//
// Ports
//   clk, rst          single clock, asynchronous active-high reset
//   mode              0 = INT8, 1 = packed INT4 (sampled per accepted byte)
//   shift[4:0]        left-shift amount, sampled on every output load
//   s_valid/s_ready   input byte handshake; s_data byte, s_last end of tensor
//   m_valid/m_ready   output value handshake; m_data value, m_last end of tensor
//   sat_clr           synchronous clear of sat_cnt (wins over an increment)
//   sat_cnt           saturated-output counter, sticks at all-ones
// -----------------------------------------------------------------------------
module dequant_stream #(
   parameter int OUT_W = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode,
   input  logic [4:0]       shift,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [7:0]       s_data,
   input  logic             s_last,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [OUT_W-1:0] m_data,
   output logic             m_last,
   input  logic             sat_clr,
   output logic [CNT_W-1:0] sat_cnt
);

`ifdef DEQUANT_STREAM_INT4_EN
   localparam logic INT4_EN = 1'b1;
`else
   localparam logic INT4_EN = 1'b0;
`endif

   // 8-bit value shifted by up to 31 needs 39 bits; OUT_W+32 always covers it
   localparam int WIDE_W = OUT_W + 32;

   typedef enum logic [0:0] {
      NIB_LO = 1'b0,
      NIB_HI = 1'b1
   } nib_state_t;

   nib_state_t       state_r;
   nib_state_t       state_nxt_s;
   logic             mode_q_r;
   logic             adv_s;
   logic             byte_int4_s;
   logic             load_s;
   logic [7:0]       q_s;
   logic             last_s;
   logic [OUT_W:0]   res_s;
   logic [3:0]       hi_nib_s;
   logic             hi_last_s;

   // Sign-extend a 4-bit nibble to an 8-bit quantized value
   function automatic logic [7:0] sext4(input logic [3:0] n);
      return {{4{n[3]}}, n};
   endfunction

   // Shift and saturate; result is {saturated_flag, value[OUT_W-1:0]}
   function automatic logic [OUT_W:0] dequant_sat(input logic [7:0] q,
                                                  input logic [4:0] sh);
      logic signed [WIDE_W-1:0] wide_v;
      logic signed [WIDE_W-1:0] max_v;
      logic signed [WIDE_W-1:0] min_v;
      logic [OUT_W:0]           res_v;
      wide_v = $signed({{(WIDE_W-8){q[7]}}, q}) <<< sh;
      max_v  = $signed({{(WIDE_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}});
      min_v  = $signed({{(WIDE_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}});
      if (wide_v > max_v) begin
         res_v = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
      end else if (wide_v < min_v) begin
         res_v = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
      end else begin
         res_v = {1'b0, wide_v[OUT_W-1:0]};
      end
      return res_v;
   endfunction

   assign adv_s       = !m_valid || m_ready;
   assign byte_int4_s = INT4_EN & mode;
   assign res_s       = dequant_sat(q_s, shift);

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= NIB_LO;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // FSM next-state logic
   always_comb begin
      state_nxt_s = NIB_LO;
      case (state_r)
         NIB_LO: begin
            if (s_valid && adv_s && byte_int4_s) begin
               state_nxt_s = NIB_HI;
            end else begin
               state_nxt_s = NIB_LO;
            end
         end
         NIB_HI: begin
            // A non-INT4 latched mode here cannot occur; fall back to NIB_LO
            if (adv_s || !mode_q_r) begin
               state_nxt_s = NIB_LO;
            end else begin
               state_nxt_s = NIB_HI;
            end
         end
         default: begin
            state_nxt_s = NIB_LO;
         end
      endcase
   end

   // FSM outputs: input handshake and selection of the value to load
   always_comb begin
      s_ready = 1'b0;
      load_s  = 1'b0;
      q_s     = 8'd0;
      last_s  = 1'b0;
      case (state_r)
         NIB_LO: begin
            s_ready = adv_s;
            if (s_valid && adv_s) begin
               load_s = 1'b1;
               if (byte_int4_s) begin
                  q_s    = sext4(s_data[3:0]);
                  last_s = 1'b0;
               end else begin
                  q_s    = s_data;
                  last_s = s_last;
               end
            end else begin
               load_s = 1'b0;
            end
         end
         NIB_HI: begin
            s_ready = 1'b0;
            if (adv_s && mode_q_r) begin
               load_s = 1'b1;
               q_s    = sext4(hi_nib_s);
               last_s = hi_last_s;
            end else begin
               load_s = 1'b0;
            end
         end
         default: begin
            s_ready = 1'b0;
            load_s  = 1'b0;
         end
      endcase
   end

   // Mode of the byte currently being unpacked
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mode_q_r <= 1'b0;
      end else if (s_valid && s_ready) begin
         mode_q_r <= mode;
      end
   end

`ifdef DEQUANT_STREAM_INT4_EN
   logic [3:0] hi_nib_r;
   logic       hi_last_r;

   // High nibble and last flag held until the low nibble has been emitted
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_nib_r  <= 4'd0;
         hi_last_r <= 1'b0;
      end else if ((state_r == NIB_LO) && s_valid && adv_s && byte_int4_s) begin
         hi_nib_r  <= s_data[7:4];
         hi_last_r <= s_last;
      end
   end

   assign hi_nib_s  = hi_nib_r;
   assign hi_last_s = hi_last_r;
`else
   assign hi_nib_s  = 4'd0;
   assign hi_last_s = 1'b0;
`endif

   // Output register: loads only when the downstream slot is free
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid <= 1'b0;
         m_data  <= {OUT_W{1'b0}};
         m_last  <= 1'b0;
      end else if (adv_s) begin
         m_valid <= load_s;
         if (load_s) begin
            m_data <= res_s[OUT_W-1:0];
            m_last <= last_s;
         end
      end
   end

   // Saturation event counter; clear beats increment, stops at all-ones
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_cnt <= {CNT_W{1'b0}};
      end else if (sat_clr) begin
         sat_cnt <= {CNT_W{1'b0}};
      end else if (load_s && res_s[OUT_W] && (sat_cnt != {CNT_W{1'b1}})) begin
         sat_cnt <= sat_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

endmodule
